// File: rtl/pwr_maestro_slave_if.sv
// AXI-lite bus bundle between the SYSCFG power controller (master) and pwr_maestro_slave.
interface pwr_maestro_slave_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] axi_aw_addr;
  logic                  axi_aw_valid;
  logic                  axi_aw_ready;
  logic [31:0]           axi_w_data;
  logic                  axi_w_valid;
  logic                  axi_w_ready;
  logic [1:0]            axi_b_resp;
  logic                  axi_b_valid;
  logic                  axi_b_ready;
  logic [ADDR_WIDTH-1:0] axi_ar_addr;
  logic                  axi_ar_valid;
  logic                  axi_ar_ready;
  logic [31:0]           axi_r_data;
  logic [1:0]            axi_r_resp;
  logic                  axi_r_valid;
  logic                  axi_r_ready;

  modport slave (
    input  axi_aw_addr, axi_aw_valid, axi_w_data, axi_w_valid, axi_b_ready,
           axi_ar_addr, axi_ar_valid, axi_r_ready,
    output axi_aw_ready, axi_w_ready, axi_b_resp, axi_b_valid,
           axi_ar_ready, axi_r_data, axi_r_resp, axi_r_valid
  );

  modport master (
    output axi_aw_addr, axi_aw_valid, axi_w_data, axi_w_valid, axi_b_ready,
           axi_ar_addr, axi_ar_valid, axi_r_ready,
    input  axi_aw_ready, axi_w_ready, axi_b_resp, axi_b_valid,
           axi_ar_ready, axi_r_data, axi_r_resp, axi_r_valid
  );
endinterface

// File: rtl/pwr_maestro_slave.sv
// AXI-lite power-domain controller: per-domain CMD/STATUS words and one shared
// sequencer stepping queued domains through isolate/reset/clock/switch.
module pwr_maestro_slave #(
  parameter int unsigned        NUM_DOM     = 8,
  parameter int unsigned        ADDR_WIDTH  = 12,
  parameter int unsigned        STEP_CYCLES = 4,
  parameter int unsigned        ACK_TIMEOUT = 256,
  parameter logic [NUM_DOM-1:0] RESET_ON    = '1
) (
  input  logic               clk,
  input  logic               rst,
  pwr_maestro_slave_if.slave axi,
  output logic [NUM_DOM-1:0] pwr_req_o,
  input  logic [NUM_DOM-1:0] pwr_ack_i,
  output logic [NUM_DOM-1:0] clk_en_o,
  output logic [NUM_DOM-1:0] dom_rst_o,
  output logic [NUM_DOM-1:0] iso_o
);
  localparam int unsigned DW = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {D_OFF = 2'd0, D_ON = 2'd1, D_DOWN = 2'd2, D_UP = 2'd3} dom_st_e;
  typedef enum logic [3:0] {SEQ_IDLE, ISO_ON, RST_ON, CLK_OFF, PWR_OFF,
                            PWR_ON, CLK_ON, RST_OFF, ISO_OFF} seq_e;

  dom_st_e            st_q [NUM_DOM];
  dom_st_e            st_d [NUM_DOM];
  logic [NUM_DOM-1:0] pend_q, pend_d, to_q, to_d, up_q, up_d;
  logic [NUM_DOM-1:0] pwr_q, pwr_d, clk_q, clk_d, rst_q, rst_d, iso_q, iso_d;
  seq_e               seq_q, seq_d;
  logic [3:0]         act_q, act_d;
  logic [15:0]        cnt_q, cnt_d, ack_cnt_q, ack_cnt_d;
  logic               acked_q, acked_d;
  logic               aw_rdy_q, aw_rdy_d, b_vld_q, b_vld_d, ar_rdy_q, ar_rdy_d, r_vld_q, r_vld_d;
  logic [1:0]         b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [31:0]        r_data_q, r_data_d;

  logic [DW-1:0]      wdom, rdom;
  logic [1:0]         wword, rword;
  logic [NUM_DOM-1:0] wsel, rsel, going, on_vec, act_oh, pick_oh;
  logic [3:0]         pick_idx;
  logic [31:0]        rdata;
  logic               wr_fire, rd_fire, is_dn, is_up, w_err, w_new, ack_ok, step_done, adv;
  logic               unused_addr_lsbs;

  assign wdom  = axi.axi_aw_addr[ADDR_WIDTH-1:4];
  assign wword = axi.axi_aw_addr[3:2];
  assign rdom  = axi.axi_ar_addr[ADDR_WIDTH-1:4];
  assign rword = axi.axi_ar_addr[3:2];
  assign unused_addr_lsbs = ^{axi.axi_aw_addr[1:0], axi.axi_ar_addr[1:0]};

  always_comb begin
    wsel = '0; rsel = '0; going = '0; on_vec = '0; act_oh = '0; rdata = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      wsel[i]   = (wdom == DW'(i));
      rsel[i]   = (rdom == DW'(i));
      going[i]  = (st_q[i] == D_DOWN) || (st_q[i] == D_UP);
      on_vec[i] = (st_q[i] == D_ON);
      act_oh[i] = (act_q == 4'(i));
      if (rsel[i]) begin
        case (rword)
          2'd0:    rdata = {28'd0, to_q[i], pend_q[i], st_q[i]};
          2'd1:    rdata = up_q[i] ? 32'd4 : 32'd3;
          default: rdata = '0;
        endcase
      end
    end
    pick_idx = '0;
    for (int unsigned i = NUM_DOM; i > 0; i--) begin
      if (pend_q[i-1]) pick_idx = 4'(i-1);
    end
    pick_oh = pend_q & (~pend_q + NUM_DOM'(1));
  end

  assign wr_fire = aw_rdy_q && axi.axi_aw_valid && axi.axi_w_valid;
  assign rd_fire = ar_rdy_q && axi.axi_ar_valid;
  assign is_dn   = (axi.axi_w_data == 32'd3);
  assign is_up   = (axi.axi_w_data == 32'd4);
  assign w_err   = !(|wsel) || (wword != 2'd1) || !(is_dn || is_up) || (|(wsel & (pend_q | going)));
  // A command equal to the stable state is accepted but starts nothing.
  assign w_new   = !w_err && (is_up ? !(|(wsel & on_vec)) : (|(wsel & on_vec)));
  assign ack_ok  = (seq_q == PWR_ON) ? (|(pwr_ack_i & act_oh)) : !(|(pwr_ack_i & act_oh));
  assign step_done = (cnt_q == 16'(STEP_CYCLES - 1));

  always_comb begin
    st_d = st_q; pend_d = pend_q; to_d = to_q; up_d = up_q;
    pwr_d = pwr_q; clk_d = clk_q; rst_d = rst_q; iso_d = iso_q;
    seq_d = seq_q; act_d = act_q; cnt_d = cnt_q; ack_cnt_d = ack_cnt_q; acked_d = acked_q;
    adv = 1'b0;
    aw_rdy_d = axi.axi_aw_valid && axi.axi_w_valid && !b_vld_q && !aw_rdy_q;
    ar_rdy_d = axi.axi_ar_valid && !r_vld_q && !ar_rdy_q;
    b_vld_d = b_vld_q; b_resp_d = b_resp_q;
    r_vld_d = r_vld_q; r_resp_d = r_resp_q; r_data_d = r_data_q;

    if (wr_fire) begin
      b_vld_d  = 1'b1;
      b_resp_d = w_err ? 2'd2 : 2'd0;
      if (w_new) begin
        pend_d = pend_d | wsel;
        to_d   = to_d & ~wsel;
        up_d   = is_up ? (up_d | wsel) : (up_d & ~wsel);
      end
    end else if (b_vld_q && axi.axi_b_ready) begin
      b_vld_d = 1'b0;
    end

    if (rd_fire) begin
      r_vld_d  = 1'b1;
      r_resp_d = (|rsel) ? 2'd0 : 2'd2;
      r_data_d = (|rsel) ? rdata : '0;
    end else if (r_vld_q && axi.axi_r_ready) begin
      r_vld_d = 1'b0;
    end

    case (seq_q)
      SEQ_IDLE: begin
        if (|pend_q) begin
          act_d = pick_idx; pend_d = pend_d & ~pick_oh;
          cnt_d = '0; ack_cnt_d = '0; acked_d = 1'b0;
          for (int unsigned i = 0; i < NUM_DOM; i++)
            if (pick_oh[i]) st_d[i] = up_q[i] ? D_UP : D_DOWN;
          if (|(pick_oh & up_q)) begin seq_d = PWR_ON;  pwr_d = pwr_q | pick_oh; end
          else                   begin seq_d = ISO_ON;  iso_d = iso_q | pick_oh; end
        end
      end
      // Switch steps first wait for power-good (or time out), then the normal step delay.
      PWR_OFF, PWR_ON: begin
        if (!acked_q) begin
          if (ack_ok || (ack_cnt_q == 16'(ACK_TIMEOUT))) begin
            acked_d = 1'b1; cnt_d = '0;
            if (!ack_ok) to_d = to_d | act_oh;
          end else begin
            ack_cnt_d = ack_cnt_q + 16'd1;
          end
        end else if (step_done) adv = 1'b1;
        else cnt_d = cnt_q + 16'd1;
      end
      default: begin
        if (step_done) adv = 1'b1;
        else cnt_d = cnt_q + 16'd1;
      end
    endcase

    if (adv) begin
      cnt_d = '0; ack_cnt_d = '0; acked_d = 1'b0;
      case (seq_q)
        ISO_ON:  begin seq_d = RST_ON;  rst_d = rst_q | act_oh;  end
        RST_ON:  begin seq_d = CLK_OFF; clk_d = clk_q & ~act_oh; end
        CLK_OFF: begin seq_d = PWR_OFF; pwr_d = pwr_q & ~act_oh; end
        PWR_ON:  begin seq_d = CLK_ON;  clk_d = clk_q | act_oh;  end
        CLK_ON:  begin seq_d = RST_OFF; rst_d = rst_q & ~act_oh; end
        RST_OFF: begin seq_d = ISO_OFF; iso_d = iso_q & ~act_oh; end
        default: begin
          seq_d = SEQ_IDLE;
          for (int unsigned i = 0; i < NUM_DOM; i++)
            if (act_oh[i]) st_d[i] = (seq_q == PWR_OFF) ? D_OFF : D_ON;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DOM; i++) st_q[i] <= RESET_ON[i] ? D_ON : D_OFF;
      pend_q <= '0; to_q <= '0; up_q <= RESET_ON;
      pwr_q <= RESET_ON; clk_q <= RESET_ON; rst_q <= ~RESET_ON; iso_q <= ~RESET_ON;
      seq_q <= SEQ_IDLE; act_q <= '0; cnt_q <= '0; ack_cnt_q <= '0; acked_q <= 1'b0;
      aw_rdy_q <= 1'b0; b_vld_q <= 1'b0; b_resp_q <= '0;
      ar_rdy_q <= 1'b0; r_vld_q <= 1'b0; r_resp_q <= '0; r_data_q <= '0;
    end else begin
      st_q <= st_d; pend_q <= pend_d; to_q <= to_d; up_q <= up_d;
      pwr_q <= pwr_d; clk_q <= clk_d; rst_q <= rst_d; iso_q <= iso_d;
      seq_q <= seq_d; act_q <= act_d; cnt_q <= cnt_d; ack_cnt_q <= ack_cnt_d; acked_q <= acked_d;
      aw_rdy_q <= aw_rdy_d; b_vld_q <= b_vld_d; b_resp_q <= b_resp_d;
      ar_rdy_q <= ar_rdy_d; r_vld_q <= r_vld_d; r_resp_q <= r_resp_d; r_data_q <= r_data_d;
    end
  end

  assign pwr_req_o = pwr_q;
  assign clk_en_o  = clk_q;
  assign dom_rst_o = rst_q;
  assign iso_o     = iso_q;
  assign axi.axi_aw_ready = aw_rdy_q;
  assign axi.axi_w_ready  = aw_rdy_q;
  assign axi.axi_b_valid  = b_vld_q;
  assign axi.axi_b_resp   = b_resp_q;
  assign axi.axi_ar_ready = ar_rdy_q;
  assign axi.axi_r_valid  = r_vld_q;
  assign axi.axi_r_resp   = r_resp_q;
  assign axi.axi_r_data   = r_data_q;
endmodule
